// File: rtl/poly_basemul.sv
// Kyber-512 NTT-domain basecase multiplier: 128 degree-1 products mod (X^2 - gamma_k), q = 3329.
// Optional accumulate mode is enabled by defining POLY_BASEMUL_ACC_EN (adds the i_acc port).
module poly_basemul (
    input  logic          i_clk,
    input  logic          i_rstn,
    input  logic          i_start,
    input  logic [3071:0] i_poly_a,
    input  logic [3071:0] i_poly_b,
`ifdef POLY_BASEMUL_ACC_EN
    input  logic          i_acc,
`endif
    output logic [3071:0] o_poly,
    output logic          o_busy,
    output logic          o_done
);

    localparam logic [11:0] Q         = 12'd3329;
    // floor(2^36 / q); with inputs below 2^26 the quotient estimate is low by at most one
    localparam logic [24:0] BARRETT_M = 25'd20642678;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic [11:0] f_mod_q(input logic [25:0] x);
        logic [50:0] prod;
        logic [14:0] t;
        logic [25:0] r;
        prod = 51'(x) * 51'(BARRETT_M);
        t    = 15'(prod >> 36);
        r    = x - 26'(t) * 26'(Q);
        if (r >= 26'(Q)) begin
            r = r - 26'(Q);
        end
        return 12'(r);
    endfunction

    function automatic logic [11:0] f_add_mod(input logic [11:0] a, input logic [11:0] b);
        logic [12:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 13'(Q)) begin
            s = s - 13'(Q);
        end
        return 12'(s);
    endfunction

    // Elaboration-time constant: 17^(2*br7(k)+1) mod q by square-and-multiply
    function automatic logic [11:0] f_gamma(input int k);
        int br;
        int e;
        int base;
        int res;
        br = 0;
        for (int i = 0; i < 7; i++) begin
            if (((k >> i) & 1) != 0) begin
                br = br | (1 << (6 - i));
            end
        end
        e    = 2 * br + 1;
        base = 17;
        res  = 1;
        for (int i = 0; i < 8; i++) begin
            if (((e >> i) & 1) != 0) begin
                res = (res * base) % 3329;
            end
            base = (base * base) % 3329;
        end
        return 12'(res);
    endfunction

    logic [127:0][11:0] w_gamma_rom;

    for (genvar gi = 0; gi < 128; gi++) begin : g_gamma_rom
        assign w_gamma_rom[gi] = f_gamma(gi);
    end

    state_t      r_state;
    logic [6:0]  r_cnt;
    logic        r_drain;
    logic        r_busy;
    logic        r_done;
    logic [11:0] r_a [256];
    logic [11:0] r_b [256];
    logic [11:0] r_poly [256];

    logic        w_accept;
    logic        w_issue;
    logic [7:0]  w_idx0;
    logic [7:0]  w_idx1;
    logic [11:0] w_a0, w_a1, w_b0, w_b1;

    assign w_accept = (r_state == ST_IDLE) && i_start;
    assign w_issue  = (r_state == ST_RUN);
    assign w_idx0   = {r_cnt, 1'b0};
    assign w_idx1   = {r_cnt, 1'b1};
    assign w_a0     = r_a[w_idx0];
    assign w_a1     = r_a[w_idx1];
    assign w_b0     = r_b[w_idx0];
    assign w_b1     = r_b[w_idx1];

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_drain <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_state <= ST_RUN;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    r_cnt <= r_cnt + 7'd1;
                    if (r_cnt == 7'd127) begin
                        r_state <= ST_DRAIN;
                        r_drain <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    r_drain <= 1'b1;
                    if (r_drain) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Operands are captured once so upstream is free to change them during the run
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int i = 0; i < 256; i++) begin
                r_a[i] <= '0;
                r_b[i] <= '0;
            end
        end else if (w_accept) begin
            for (int i = 0; i < 256; i++) begin
                r_a[i] <= i_poly_a[12*i +: 12];
                r_b[i] <= i_poly_b[12*i +: 12];
            end
        end
    end

    logic        r_s1_valid;
    logic [23:0] r_s1_p00, r_s1_p11, r_s1_p01, r_s1_p10;
    logic [11:0] r_s1_gamma;
    logic [6:0]  r_s1_k;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_s1_valid <= 1'b0;
            r_s1_p00   <= '0;
            r_s1_p11   <= '0;
            r_s1_p01   <= '0;
            r_s1_p10   <= '0;
            r_s1_gamma <= '0;
            r_s1_k     <= '0;
        end else begin
            r_s1_valid <= w_issue;
            if (w_issue) begin
                r_s1_p00   <= 24'(w_a0) * 24'(w_b0);
                r_s1_p11   <= 24'(w_a1) * 24'(w_b1);
                r_s1_p01   <= 24'(w_a0) * 24'(w_b1);
                r_s1_p10   <= 24'(w_a1) * 24'(w_b0);
                r_s1_gamma <= w_gamma_rom[r_cnt];
                r_s1_k     <= r_cnt;
            end
        end
    end

    logic        r_s2_valid;
    logic [11:0] r_s2_a0b0, r_s2_a1b1, r_s2_r1;
    logic [11:0] r_s2_gamma;
    logic [6:0]  r_s2_k;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_s2_valid <= 1'b0;
            r_s2_a0b0  <= '0;
            r_s2_a1b1  <= '0;
            r_s2_r1    <= '0;
            r_s2_gamma <= '0;
            r_s2_k     <= '0;
        end else begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_a0b0  <= f_mod_q(26'(r_s1_p00));
                r_s2_a1b1  <= f_mod_q(26'(r_s1_p11));
                r_s2_r1    <= f_mod_q(26'(r_s1_p01) + 26'(r_s1_p10));
                r_s2_gamma <= r_s1_gamma;
                r_s2_k     <= r_s1_k;
            end
        end
    end

    logic [25:0] w_s3_sum;
    logic [11:0] w_r0;
    logic [11:0] w_wr0;
    logic [11:0] w_wr1;

    // Sum stays below 2^24: (q-1)^2 + (q-1)
    assign w_s3_sum = 26'(r_s2_a1b1) * 26'(r_s2_gamma) + 26'(r_s2_a0b0);
    assign w_r0     = f_mod_q(w_s3_sum);

`ifdef POLY_BASEMUL_ACC_EN
    logic r_acc;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_acc <= 1'b0;
        end else if (w_accept) begin
            r_acc <= i_acc;
        end
    end

    assign w_wr0 = r_acc ? f_add_mod(r_poly[{r_s2_k, 1'b0}], w_r0)    : w_r0;
    assign w_wr1 = r_acc ? f_add_mod(r_poly[{r_s2_k, 1'b1}], r_s2_r1) : r_s2_r1;
`else
    assign w_wr0 = w_r0;
    assign w_wr1 = r_s2_r1;
`endif

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int i = 0; i < 256; i++) begin
                r_poly[i] <= '0;
            end
        end else if (r_s2_valid) begin
            r_poly[{r_s2_k, 1'b0}] <= w_wr0;
            r_poly[{r_s2_k, 1'b1}] <= w_wr1;
        end
    end

    for (genvar gi = 0; gi < 256; gi++) begin : g_out_pack
        assign o_poly[12*gi +: 12] = r_poly[gi];
    end

    assign o_busy = r_busy;
    assign o_done = r_done;

endmodule

// File: tb/tb_poly_basemul.sv
// Bench for poly_basemul: arithmetic reference model plus directed vectors with literal expectations.
module tb_poly_basemul;

    localparam int Q = 3329;

    logic          clk  = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic [3071:0] pa = '0;
    logic [3071:0] pb = '0;
    logic [3071:0] poly;
    logic          busy;
    logic          done;
`ifdef POLY_BASEMUL_ACC_EN
    logic          acc = 1'b0;
`endif

    always #5 clk = ~clk;

    poly_basemul dut (
        .i_clk    (clk),
        .i_rstn   (rstn),
        .i_start  (start),
        .i_poly_a (pa),
        .i_poly_b (pb),
`ifdef POLY_BASEMUL_ACC_EN
        .i_acc    (acc),
`endif
        .o_poly   (poly),
        .o_busy   (busy),
        .o_done   (done)
    );

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    int ta [256];
    int tbv[256];

    int exp_poly[256];
    int ma[256];
    int mb[256];
    bit m_active = 1'b0;
    int m_edge   = 0;
    bit m_acc    = 1'b0;

    // gamma_k straight from the definition: repeated multiplication by 17
    function automatic int gam(input int k);
        int br;
        int r;
        br = 0;
        for (int i = 0; i < 7; i++)
            if (((k >> i) & 1) != 0) br = br | (1 << (6 - i));
        r = 1;
        for (int i = 0; i < 2 * br + 1; i++) r = (r * 17) % Q;
        return r;
    endfunction

    function automatic int coef(input logic [3071:0] v, input int j);
        return int'(v[12*j +: 12]);
    endfunction

    task automatic check(input string name, input int got, input int expv);
        checks++;
        if (got != expv) begin
            errors++;
            $display("FAIL %s t=%0t got=%0d exp=%0d", name, $time, got, expv);
        end
    endtask

    // Reference model: operands captured at the start edge, pair k lands k+3 edges later
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_active = 1'b0;
            m_edge   = 0;
            for (int j = 0; j < 256; j++) exp_poly[j] = 0;
        end else if (!m_active) begin
            if (start) begin
                m_active = 1'b1;
                m_edge   = 0;
                for (int j = 0; j < 256; j++) begin
                    ma[j] = int'(pa[12*j +: 12]);
                    mb[j] = int'(pb[12*j +: 12]);
                end
`ifdef POLY_BASEMUL_ACC_EN
                m_acc = acc;
`endif
            end
        end else begin
            m_edge++;
            if (m_edge >= 3 && m_edge <= 130) begin
                int k;
                longint r0;
                longint r1;
                k  = m_edge - 3;
                r0 = (longint'(ma[2*k]) * mb[2*k]
                      + longint'(ma[2*k+1]) * mb[2*k+1] * gam(k)) % Q;
                r1 = (longint'(ma[2*k]) * mb[2*k+1] + longint'(ma[2*k+1]) * mb[2*k]) % Q;
                if (m_acc) begin
                    r0 = (r0 + exp_poly[2*k]) % Q;
                    r1 = (r1 + exp_poly[2*k+1]) % Q;
                end
                exp_poly[2*k]   = int'(r0);
                exp_poly[2*k+1] = int'(r1);
            end
            if (m_edge == 131) m_active = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            int nd;
            int first;
            check("busy", int'(busy), int'(m_active));
            check("done", int'(done), int'(m_active && m_edge == 130));
            nd    = 0;
            first = -1;
            for (int j = 0; j < 256; j++) begin
                if (coef(poly, j) != exp_poly[j]) begin
                    nd++;
                    if (first < 0) first = j;
                end
            end
            checks++;
            if (nd != 0) begin
                errors++;
                $display("FAIL poly t=%0t coeff %0d got=%0d exp=%0d (%0d coeffs differ)",
                         $time, first, coef(poly, first), exp_poly[first], nd);
            end
        end
    end

    task automatic clear_ops();
        for (int j = 0; j < 256; j++) begin
            ta[j]  = 0;
            tbv[j] = 0;
        end
    endtask

    task automatic fill_ops(input int v);
        for (int j = 0; j < 256; j++) begin
            ta[j]  = v;
            tbv[j] = v;
        end
    endtask

    // Start a run; optionally pulse i_start again (with scrambled operands) at edge inject_at
    task automatic run(input string name, input int inject_at);
        int n;
        int n_done;
        bit finished;
        @(posedge clk); #2;
        for (int j = 0; j < 256; j++) begin
            pa[12*j +: 12] = 12'(ta[j]);
            pb[12*j +: 12] = 12'(tbv[j]);
        end
        start = 1'b1;
        @(posedge clk); #2;
        start    = 1'b0;
        n        = 0;
        n_done   = -1;
        finished = 1'b0;
        while (!finished && n < 300) begin
            @(posedge clk);
            n++;
            #1;
            if (n_done < 0 && done) n_done = n;
            else if (n_done >= 0) begin
                check({name, "_done_width"}, int'(done), 0);
                finished = 1'b1;
            end
            #1;
            start = (inject_at > 0 && n + 1 == inject_at);
            if (start) begin
                pa = ~pa;
                pb = pa ^ pb;
            end
        end
        start = 1'b0;
        if (!finished) check({name, "_timeout"}, 0, 1);
        check({name, "_latency"}, n_done, 130);
    endtask

    task automatic zeros_except(input string name, input int j0, input int j1);
        int nz;
        nz = 0;
        for (int j = 0; j < 256; j++)
            if (j != j0 && j != j1 && coef(poly, j) != 0) nz++;
        check({name, "_others_zero"}, nz, 0);
    endtask

    initial begin
        int cnt;
        int bad;

        repeat (3) @(posedge clk);
        #2;
        rstn   = 1'b1;
        chk_en = 1'b1;
        check("reset_busy", int'(busy), 0);
        check("reset_poly_coeff0", coef(poly, 0), 0);

        // model pins
        check("model_gamma0", gam(0), 17);
        check("model_gamma1", gam(1), 3312);

        clear_ops();
        ta[0] = 1; tbv[0] = 1;
        run("unit", 0);
        check("unit_coeff0", coef(poly, 0), 1);
        zeros_except("unit", 0, 0);

        clear_ops();
        ta[1] = 1; tbv[1] = 1; ta[3] = 1; tbv[3] = 1;
        run("gamma", 0);
        check("gamma_coeff0", coef(poly, 0), 17);
        check("gamma_coeff2", coef(poly, 2), 3312);
        zeros_except("gamma", 0, 2);

        fill_ops(3328);
        run("minus1", 0);
        check("minus1_coeff0", coef(poly, 0), 18);
        check("minus1_coeff2", coef(poly, 2), 3313);
        bad = 0;
        for (int k = 0; k < 128; k++) begin
            if (coef(poly, 2*k+1) != 2) bad++;
            if (coef(poly, 2*k) != (1 + gam(k)) % Q) bad++;
        end
        check("minus1_all_pairs", bad, 0);

        clear_ops();
        ta[0] = 4095; tbv[0] = 2;
        run("unreduced", 0);
        check("unreduced_coeff0", coef(poly, 0), 1532);
        check("unreduced_coeff1", coef(poly, 1), 0);

        clear_ops();
        ta[0] = 1; tbv[0] = 1;
        run("restart_ignored", 50);
        check("restart_ignored_coeff0", coef(poly, 0), 1);
        zeros_except("restart_ignored", 0, 0);

        // reset in the middle of a run
        fill_ops(3328);
        @(posedge clk); #2;
        for (int j = 0; j < 256; j++) begin
            pa[12*j +: 12] = 12'(ta[j]);
            pb[12*j +: 12] = 12'(tbv[j]);
        end
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (59) @(posedge clk);
        #2;
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", int'(busy), 0);
        bad = 0;
        for (int j = 0; j < 256; j++) if (coef(poly, j) != 0) bad++;
        check("rst_poly_zero", bad, 0);
        #1;
        rstn = 1'b1;
        cnt  = 0;
        for (int i = 0; i < 150; i++) begin
            @(posedge clk); #1;
            if (done) cnt++;
        end
        check("rst_no_done", cnt, 0);

        clear_ops();
        ta[0] = 1; tbv[0] = 1;
        run("after_rst", 0);
        check("after_rst_coeff0", coef(poly, 0), 1);

`ifdef POLY_BASEMUL_ACC_EN
        acc = 1'b0;
        run("acc0", 0);
        check("acc0_coeff0", coef(poly, 0), 1);
        acc = 1'b1;
        run("acc1", 0);
        check("acc1_coeff0", coef(poly, 0), 2);
        acc = 1'b0;
        run("acc2", 0);
        check("acc2_coeff0", coef(poly, 0), 1);
`endif

        repeat (2) @(posedge clk);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t got=running exp=finished", $time);
        $fatal(1);
    end

endmodule
